// File: rtl/cell_histogram_reader_if.sv
// Histogram beat stream between the cell histogram reader and the block normaliser.
// One bin sum per beat, valid/ready handshake.
interface cell_histogram_reader_if #(
    parameter int SW = 17
);
    logic          histValid;
    logic          histReady;
    logic [3:0]    histBin;
    logic [SW-1:0] histSum;
    logic          histLastBin;
    logic          histLastCell;

    modport master (
        output histValid, histBin, histSum, histLastBin, histLastCell,
        input  histReady
    );

    modport slave (
        input  histValid, histBin, histSum, histLastBin, histLastCell,
        output histReady
    );
endinterface

// File: rtl/cell_histogram_reader.sv
// Per-cell orientation histograms over 2 rows x CELL_WIDTH columns, ping-pong banks.
// Define CELL_HIST_TOTAL_EN to append a per-cell total beat (histSum widened by 4 bits).
module cell_histogram_reader #(
    parameter int IMAGE_WIDTH = 1280,
    parameter int CELL_WIDTH  = 16,
    parameter int NUM_BINS    = 9
) (
    input  logic                    pclk,
    input  logic                    reset_n,
    input  logic                    deIn,
    input  logic [3:0]              bottomBinIn,
    input  logic [3:0]              topBinIn,
    input  logic [11:0]             bottomModulusIn,
    input  logic [11:0]             topModulusIn,
    cell_histogram_reader_if.master hist,
    output logic                    overrun
);
    localparam int SUM_W = 12 + $clog2(2 * CELL_WIDTH);
`ifdef CELL_HIST_TOTAL_EN
    localparam int OUT_W = SUM_W + 4;
    localparam int BEATS = NUM_BINS + 1;
`else
    localparam int OUT_W = SUM_W;
    localparam int BEATS = NUM_BINS;
`endif
    localparam int CNT_W = $clog2(CELL_WIDTH + 1);
    localparam int COL_W = $clog2(IMAGE_WIDTH + 1);

    typedef enum logic {IDLE, DRAIN} state_t;

    state_t           state;
    logic [SUM_W-1:0] acc     [NUM_BINS];
    logic [SUM_W-1:0] drn     [NUM_BINS];
    logic [SUM_W-1:0] acc_nxt [NUM_BINS];
    logic [CNT_W-1:0] cell_cnt;
    logic [COL_W-1:0] col;
    logic [3:0]       beat;
    logic             tag;
    logic             cell_full;
    logic             line_end;
    logic             close_cell;
    logic             close_tag;
    logic             accept;
    logic             last_beat;
    logic             drn_free;

    always_comb begin
        for (int b = 0; b < NUM_BINS; b++) begin
            acc_nxt[b] = acc[b];
            if (deIn && topBinIn == 4'(b))
                acc_nxt[b] = acc_nxt[b] + SUM_W'(topModulusIn);
            if (deIn && bottomBinIn == 4'(b))
                acc_nxt[b] = acc_nxt[b] + SUM_W'(bottomModulusIn);
        end
    end

    assign cell_full  = deIn && cell_cnt == CNT_W'(CELL_WIDTH - 1);
    assign line_end   = !deIn && cell_cnt != '0;
    assign close_cell = cell_full || line_end;
    // A full cell ending on the line's last pixel is tagged here: the idle edge after it sees an empty ACC
    assign close_tag  = line_end || col == COL_W'(IMAGE_WIDTH - 1);
    assign accept     = hist.histValid && hist.histReady;
    assign last_beat  = beat == 4'(BEATS - 1);
    assign drn_free   = state == IDLE || (accept && last_beat);

    assign hist.histValid    = state == DRAIN;
    assign hist.histBin      = beat;
    assign hist.histLastBin  = hist.histValid && last_beat;
    assign hist.histLastCell = hist.histLastBin && tag;

`ifdef CELL_HIST_TOTAL_EN
    logic [OUT_W-1:0] total;

    always_comb begin
        total = '0;
        for (int b = 0; b < NUM_BINS; b++)
            total = total + OUT_W'(drn[b]);
    end
`endif

    always_comb begin
        hist.histSum = '0;
        for (int b = 0; b < NUM_BINS; b++)
            if (beat == 4'(b))
                hist.histSum = OUT_W'(drn[b]);
`ifdef CELL_HIST_TOTAL_EN
        if (beat == 4'(NUM_BINS))
            hist.histSum = total;
`endif
    end

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            beat     <= '0;
            tag      <= 1'b0;
            cell_cnt <= '0;
            col      <= '0;
            overrun  <= 1'b0;
            for (int b = 0; b < NUM_BINS; b++) begin
                acc[b] <= '0;
                drn[b] <= '0;
            end
        end else begin
            if (!deIn)
                col <= '0;
            else if (col != COL_W'(IMAGE_WIDTH))
                col <= col + 1'b1;

            if (close_cell)
                cell_cnt <= '0;
            else if (deIn)
                cell_cnt <= cell_cnt + 1'b1;

            for (int b = 0; b < NUM_BINS; b++)
                acc[b] <= close_cell ? '0 : acc_nxt[b];

            if (accept) begin
                if (last_beat) begin
                    state <= IDLE;
                    beat  <= '0;
                    tag   <= 1'b0;
                    for (int b = 0; b < NUM_BINS; b++)
                        drn[b] <= '0;
                end else begin
                    beat <= beat + 1'b1;
                end
            end

            // A swap on the same edge as the final acceptance overrides the clear above
            if (close_cell) begin
                if (drn_free) begin
                    state <= DRAIN;
                    beat  <= '0;
                    tag   <= close_tag;
                    for (int b = 0; b < NUM_BINS; b++)
                        drn[b] <= acc_nxt[b];
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_cell_histogram_reader.sv
// Randomised bench for cell_histogram_reader against a per-line histogram model.
// Honours CELL_HIST_TOTAL_EN for the extra total beat.
module tb_cell_histogram_reader;
    localparam int IW    = 40;
    localparam int CW    = 16;
    localparam int NB    = 9;
    localparam int SUM_W = 12 + $clog2(2 * CW);
`ifdef CELL_HIST_TOTAL_EN
    localparam int OW  = SUM_W + 4;
    localparam bit TOT = 1'b1;
`else
    localparam int OW  = SUM_W;
    localparam bit TOT = 1'b0;
`endif
    localparam int NBT = NB + (TOT ? 1 : 0);

    typedef struct packed {
        logic [11:0] tm;
        logic [3:0]  tb;
        logic [11:0] bm;
        logic [3:0]  bb;
    } px_t;

    typedef struct packed {
        logic [3:0]    bin;
        logic [OW-1:0] sum;
        logic          lb;
        logic          lc;
    } beat_t;

    logic        pclk = 1'b0;
    logic        reset_n = 1'b0;
    logic        deIn = 1'b0;
    logic [3:0]  bottomBinIn = '0;
    logic [3:0]  topBinIn = '0;
    logic [11:0] bottomModulusIn = '0;
    logic [11:0] topModulusIn = '0;
    logic        overrun;

    cell_histogram_reader_if #(.SW(OW)) hif ();

    cell_histogram_reader #(
        .IMAGE_WIDTH(IW),
        .CELL_WIDTH (CW),
        .NUM_BINS   (NB)
    ) dut (
        .pclk           (pclk),
        .reset_n        (reset_n),
        .deIn           (deIn),
        .bottomBinIn    (bottomBinIn),
        .topBinIn       (topBinIn),
        .bottomModulusIn(bottomModulusIn),
        .topModulusIn   (topModulusIn),
        .hist           (hif),
        .overrun        (overrun)
    );

    always #5 pclk = ~pclk;

    beat_t obs[$];
    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    always @(negedge pclk) begin
        beat_t b;
        if (reset_n && hif.histValid && hif.histReady) begin
            b.bin = hif.histBin;
            b.sum = hif.histSum;
            b.lb  = hif.histLastBin;
            b.lc  = hif.histLastCell;
            obs.push_back(b);
        end
    end

    function automatic beat_t cur_beat();
        beat_t b;
        b.bin = hif.histBin;
        b.sum = hif.histSum;
        b.lb  = hif.histLastBin;
        b.lc  = hif.histLastCell;
        return b;
    endfunction

    // Reference: a cell is just the bin-wise sum of its pixels' magnitudes
    function automatic void emit(input longint s[NB], input bit t);
        beat_t  b;
        longint tot = 0;
        for (int i = 0; i < NB; i++) begin
            tot   += s[i];
            b.bin = 4'(i);
            b.sum = OW'(s[i]);
            b.lb  = (i == NB - 1) && !TOT;
            b.lc  = b.lb && t;
            exp_q.push_back(b);
        end
        if (TOT) begin
            b.bin = 4'(NB);
            b.sum = OW'(tot);
            b.lb  = 1'b1;
            b.lc  = t;
            exp_q.push_back(b);
        end
    endfunction

    function automatic void model_line(input px_t line[$]);
        longint s[NB];
        int     n = 0;
        foreach (s[i]) s[i] = 0;
        for (int k = 0; k < line.size(); k++) begin
            if (line[k].tb < NB) s[line[k].tb] += line[k].tm;
            if (line[k].bb < NB) s[line[k].bb] += line[k].bm;
            n++;
            if (n == CW) begin
                emit(s, (k + 1) == IW);
                foreach (s[i]) s[i] = 0;
                n = 0;
            end
        end
        if (n > 0) emit(s, 1'b1);
    endfunction

    function automatic px_t mkpx(int tb, int tm, int bb, int bm);
        px_t p;
        p.tb = 4'(tb);
        p.tm = 12'(tm);
        p.bb = 4'(bb);
        p.bm = 12'(bm);
        return p;
    endfunction

    function automatic void rand_line(input int len, output px_t q[$]);
        q = {};
        for (int i = 0; i < len; i++)
            q.push_back(mkpx($urandom_range(0, 15), $urandom_range(0, 4095),
                             $urandom_range(0, 15), $urandom_range(0, 4095)));
    endfunction

    task automatic step(input logic de, input px_t p);
        @(posedge pclk);
        #1;
        deIn            = de;
        topBinIn        = p.tb;
        topModulusIn    = p.tm;
        bottomBinIn     = p.bb;
        bottomModulusIn = p.bm;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0);
    endtask

    task automatic run_line(input px_t line[$], input int gap);
        model_line(line);
        foreach (line[k]) step(1'b1, line[k]);
        idle(gap);
    endtask

    task automatic collect(input int n, output bit to);
        int budget = 0;
        while (obs.size() < n && budget < 2000) begin
            @(posedge pclk);
            budget++;
        end
        to = obs.size() < n;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        hif.histReady = 1'b1;
        #2;
        checks++;
        if (hif.histValid !== 1'b0 || overrun !== 1'b0 || hif.histSum !== '0 ||
            hif.histLastBin !== 1'b0 || hif.histLastCell !== 1'b0 || hif.histBin !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b ovr=%b bin=%0d sum=%0d lb=%b lc=%b, want all 0",
                     hif.histValid, overrun, hif.histBin, hif.histSum, hif.histLastBin, hif.histLastCell);
        end
        repeat (3) @(posedge pclk);
        #1 reset_n = 1'b1;
        idle(2);
        checks++;
        if (hif.histValid !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got valid=%b ovr=%b, want 0 0", hif.histValid, overrun);
        end
    endtask

    task automatic test_basic();
        px_t line[$];
        bit  to;
        for (int i = 0; i < CW; i++) line.push_back(mkpx(2, 100, 5, 7));
        model_line(line);
        for (int i = 0; i < CW; i++) step(1'b1, line[i]);
        @(negedge pclk);
        checks++;
        if (hif.histValid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_valid: got %b, want 0", hif.histValid);
        end
        step(1'b0, '0);
        @(negedge pclk);
        checks++;
        if (hif.histValid !== 1'b1 || hif.histBin !== 4'd0) begin
            errors++;
            $display("FAIL basic_valid_rise: got valid=%b bin=%0d, want 1 0", hif.histValid, hif.histBin);
        end
        idle(14);
        collect(exp_q.size(), to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL basic_timeout: got %0d beats, want %0d", obs.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL basic beat %0d: got bin=%0d sum=%0d lb=%b lc=%b, want bin=%0d sum=%0d lb=%b lc=%b",
                             i, obs[i].bin, obs[i].sum, obs[i].lb, obs[i].lc,
                             exp_q[i].bin, exp_q[i].sum, exp_q[i].lb, exp_q[i].lc);
                end
            end
            checks++;
            if (obs[2].sum !== OW'(1600) || obs[5].sum !== OW'(112)) begin
                errors++;
                $display("FAIL basic_sums: got bin2=%0d bin5=%0d, want 1600 112", obs[2].sum, obs[5].sum);
            end
        end
        obs.delete();
        exp_q.delete();
    endtask

    task automatic test_same_bin();
        px_t line[$];
        bit  to;
        for (int i = 0; i < CW; i++) line.push_back(mkpx(0, 4095, 0, 4095));
        run_line(line, 12);
        line = {};
        for (int i = 0; i < CW; i++) line.push_back(mkpx(12, 4095, 2, 1));
        run_line(line, 12);
        collect(exp_q.size(), to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL same_bin_timeout: got %0d beats, want %0d", obs.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL same_bin beat %0d: got bin=%0d sum=%0d lb=%b lc=%b, want bin=%0d sum=%0d lb=%b lc=%b",
                             i, obs[i].bin, obs[i].sum, obs[i].lb, obs[i].lc,
                             exp_q[i].bin, exp_q[i].sum, exp_q[i].lb, exp_q[i].lc);
                end
            end
            checks++;
            if (obs[0].sum !== OW'(131040)) begin
                errors++;
                $display("FAIL same_bin_max: got %0d, want 131040", obs[0].sum);
            end
        end
        obs.delete();
        exp_q.delete();
    endtask

    task automatic test_line();
        px_t line[$];
        bit  to;
        for (int i = 0; i < IW; i++) line.push_back(mkpx(1, 1, 1, 1));
        run_line(line, 14);
        collect(exp_q.size(), to);
        idle(5);
        checks++;
        if (to || obs.size() != exp_q.size()) begin
            errors++;
            $display("FAIL line_count: got %0d beats, want %0d", obs.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL line beat %0d: got bin=%0d sum=%0d lb=%b lc=%b, want bin=%0d sum=%0d lb=%b lc=%b",
                             i, obs[i].bin, obs[i].sum, obs[i].lb, obs[i].lc,
                             exp_q[i].bin, exp_q[i].sum, exp_q[i].lb, exp_q[i].lc);
                end
            end
            checks++;
            if (obs[NBT + 1].sum !== OW'(32) || obs[2 * NBT + 1].sum !== OW'(16) ||
                obs[3 * NBT - 1].lc !== 1'b1) begin
                errors++;
                $display("FAIL line_cells: got c2=%0d c3=%0d lc=%b, want 32 16 1",
                         obs[NBT + 1].sum, obs[2 * NBT + 1].sum, obs[3 * NBT - 1].lc);
            end
        end
        obs.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        px_t line[$];
        bit  to;
        int  len;
        int  m;
        int  rem;
        for (int n = 0; n < 10; n++) begin
            m = $urandom_range(0, 2);
            if (m == 0) begin
                len = $urandom_range(1, 15);
            end else begin
                rem = $urandom_range(0, 6);
                len = 16 * m + (rem == 0 ? 0 : rem + 9);
            end
            rand_line(len, line);
            run_line(line, 12);
        end
        line = {};
        rand_line(48, line);
        run_line(line, 12);
        collect(exp_q.size(), to);
        idle(5);
        checks++;
        if (to || obs.size() != exp_q.size()) begin
            errors++;
            $display("FAIL random_count: got %0d beats, want %0d", obs.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL random beat %0d: got bin=%0d sum=%0d lb=%b lc=%b, want bin=%0d sum=%0d lb=%b lc=%b",
                             i, obs[i].bin, obs[i].sum, obs[i].lb, obs[i].lc,
                             exp_q[i].bin, exp_q[i].sum, exp_q[i].lb, exp_q[i].lc);
                end
            end
        end
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL random_overrun: got %b, want 0", overrun);
        end
        obs.delete();
        exp_q.delete();
    endtask

    task automatic test_overrun();
        px_t c1[$];
        px_t c2[$];
        bit  to;
        int  bad = 0;
        for (int i = 0; i < CW; i++) c1.push_back(mkpx(0, 10, 4, 20));
        for (int i = 0; i < CW; i++) c2.push_back(mkpx(6, 50, 6, 1));
        model_line(c1);
        step(1'b0, '0);
        hif.histReady = 1'b0;
        foreach (c1[k]) step(1'b1, c1[k]);
        foreach (c2[k]) step(1'b1, c2[k]);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0);
            @(negedge pclk);
            if (hif.histValid !== 1'b1 || cur_beat() !== exp_q[0]) bad++;
        end
        checks++;
        if (bad != 0 || obs.size() != 0) begin
            errors++;
            $display("FAIL overrun_hold: got %0d unstable cycles, %0d beats, want 0 0", bad, obs.size());
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %b, want 1", overrun);
        end
        step(1'b0, '0);
        hif.histReady = 1'b1;
        collect(exp_q.size(), to);
        idle(30);
        checks++;
        if (to || obs.size() != exp_q.size()) begin
            errors++;
            $display("FAIL overrun_count: got %0d beats, want %0d", obs.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL overrun beat %0d: got bin=%0d sum=%0d lb=%b lc=%b, want bin=%0d sum=%0d lb=%b lc=%b",
                             i, obs[i].bin, obs[i].sum, obs[i].lb, obs[i].lc,
                             exp_q[i].bin, exp_q[i].sum, exp_q[i].lb, exp_q[i].lc);
                end
            end
        end
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_sticky: got %b, want 1", overrun);
        end
        obs.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid_drain();
        px_t line[$];
        bit  to;
        rand_line(CW + 5, line);
        step(1'b0, '0);
        hif.histReady = 1'b0;
        foreach (line[k]) step(1'b1, line[k]);
        @(posedge pclk);
        #3;
        reset_n = 1'b0;
        deIn    = 1'b0;
        #1;
        checks++;
        if (hif.histValid !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_drain: got valid=%b ovr=%b, want 0 0", hif.histValid, overrun);
        end
        obs.delete();
        exp_q.delete();
        repeat (2) @(posedge pclk);
        #1;
        reset_n = 1'b1;
        hif.histReady = 1'b1;
        line = {};
        for (int i = 0; i < CW; i++) line.push_back(mkpx(2, 100, 5, 7));
        run_line(line, 14);
        collect(exp_q.size(), to);
        idle(5);
        checks++;
        if (to || obs.size() != exp_q.size()) begin
            errors++;
            $display("FAIL post_reset_count: got %0d beats, want %0d", obs.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL post_reset beat %0d: got bin=%0d sum=%0d lb=%b lc=%b, want bin=%0d sum=%0d lb=%b lc=%b",
                             i, obs[i].bin, obs[i].sum, obs[i].lb, obs[i].lc,
                             exp_q[i].bin, exp_q[i].sum, exp_q[i].lb, exp_q[i].lc);
                end
            end
        end
        obs.delete();
        exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_same_bin();
        test_line();
        test_random();
        test_overrun();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
